apb_switch_gpio: RTL and testbench

Parametrised APB slave for up to APB_DATA_WIDTH board switch/GPIO inputs. It is the successor to the single-register switch reader. Per channel it adds:
- 2-flop synchronisation
- configurable debounce
- rise/fall edge capture into a W1C status register
- a masked, level interrupt

It sits on the DMA subsystem's APB peripheral bus; o_irq goes to the interrupt aggregator.

---
 rtl/apb_switch_gpio_pkg.sv | 18 +
 rtl/apb_switch_gpio_debounce.sv | 57 +++++
 rtl/apb_switch_gpio.sv | 101 ++++++++++
 tb/tb_apb_switch_gpio.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_switch_gpio_pkg.sv
// apb_switch_gpio_pkg: shared offsets, APB state type and debounce counter sizing
//   GPIO_*_OFS  : 5-bit register byte offsets
//   apb_state_t : APB transfer state (idle / ready)
//   deb_width() : debounce counter width for a given stable-cycle count
package apb_switch_gpio_pkg;
   localparam logic [4:0] GPIO_DATA_OFS = 5'h00;
   localparam logic [4:0] GPIO_RAW_OFS  = 5'h04;
   localparam logic [4:0] GPIO_RISE_OFS = 5'h08;
   localparam logic [4:0] GPIO_FALL_OFS = 5'h0C;
   localparam logic [4:0] GPIO_STAT_OFS = 5'h10;
   localparam logic [4:0] GPIO_MASK_OFS = 5'h14;

   typedef enum logic {APB_IDLE, APB_READY} apb_state_t;

   function automatic int deb_width(input int d);
      return (d < 1) ? 1 : $clog2(d + 1);
   endfunction
endpackage

// File: rtl/apb_switch_gpio_debounce.sv
// switch_debounce: one switch channel - 2-flop sync, debounce, edge pulses
//   pclk, pnreset : clock, async active-low reset
//   sw            : asynchronous switch input
//   raw           : synchronised value
//   deb           : debounced value
//   rise, fall    : high in the cycle before the edge that moves deb 0->1 / 1->0
module switch_debounce import apb_switch_gpio_pkg::*; #(
   parameter int D = 4
) (
   input  logic pclk,
   input  logic pnreset,
   input  logic sw,
   output logic raw,
   output logic deb,
   output logic rise,
   output logic fall
);
   logic s1, s2;

   always_ff @(posedge pclk or negedge pnreset)
      if (!pnreset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end

   assign raw = s2;

   if (D == 0) begin : g_bypass
      // deb follows s2, so its update edge is the one that moves s1 into s2
      assign deb  = s2;
      assign rise = s1 & ~s2;
      assign fall = ~s1 & s2;
   end else begin : g_deb
      localparam int CW = deb_width(D);
      logic [CW-1:0] cnt;
      logic          val;
      logic          hit;

      assign hit = (s2 != val) && (cnt == CW'(D - 1));

      always_ff @(posedge pclk or negedge pnreset)
         if (!pnreset) begin
            cnt <= '0;
            val <= 1'b0;
         end else begin
            val <= hit ? s2 : val;
            cnt <= (s2 == val || hit) ? '0 : cnt + 1'b1;
         end

      assign deb  = val;
      assign rise = hit & s2;
      assign fall = hit & ~s2;
   end
endmodule

// File: rtl/apb_switch_gpio.sv
// apb_switch_gpio: APB slave for debounced switch inputs with edge status and masked irq
//   pclk, pnreset      : clock, async active-low reset
//   i_psel..i_pwdata   : APB request
//   i_switch           : asynchronous switch inputs
//   o_pready, o_prdata, o_pslverr : APB response (one wait state)
//   o_irq              : registered |(STATUS & IRQ_MASK)
module apb_switch_gpio import apb_switch_gpio_pkg::*; #(
   parameter int APB_ADDR_WIDTH  = 16,
   parameter int APB_DATA_WIDTH  = 16,
   parameter int NUM_CH          = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                      pclk,
   input  logic                      pnreset,
   input  logic                      i_psel,
   input  logic                      i_penable,
   input  logic                      i_pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
   input  logic [APB_DATA_WIDTH-1:0] i_pwdata,
   input  logic [NUM_CH-1:0]         i_switch,
   output logic                      o_pready,
   output logic [APB_DATA_WIDTH-1:0] o_prdata,
   output logic                      o_pslverr,
   output logic                      o_irq
);
   apb_state_t                state, state_nx;
   logic [NUM_CH-1:0]         raw, deb, rise, fall;
   logic [NUM_CH-1:0]         rise_en, fall_en, status, mask;
   logic [NUM_CH-1:0]         wd, set, clr;
   logic [APB_ADDR_WIDTH:0]   addr_ext;
   logic [4:0]                ofs;
   logic                      addr_ok, access, wr;
   logic [APB_DATA_WIDTH-1:0] rdata;
   logic                      unused_wdata;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      switch_debounce #(.D(DEBOUNCE_CYCLES)) u_deb (
         .pclk    (pclk),
         .pnreset (pnreset),
         .sw      (i_switch[c]),
         .raw     (raw[c]),
         .deb     (deb[c]),
         .rise    (rise[c]),
         .fall    (fall[c])
      );
   end

   // zero-extended copy so the upper-bit check also works when the bus is only 5 bits wide
   assign addr_ext     = {1'b0, i_paddr};
   assign ofs          = i_paddr[4:0];
   assign addr_ok      = ~|(addr_ext >> 5) &&
                         (ofs == GPIO_DATA_OFS || ofs == GPIO_RAW_OFS  || ofs == GPIO_RISE_OFS ||
                          ofs == GPIO_FALL_OFS || ofs == GPIO_STAT_OFS || ofs == GPIO_MASK_OFS);
   assign access       = i_psel & i_penable & (state == APB_IDLE);
   assign wr           = access & i_pwrite & addr_ok;
   assign wd           = i_pwdata[NUM_CH-1:0];
   assign unused_wdata = ^i_pwdata;
   assign set          = (rise & rise_en) | (fall & fall_en);
   assign clr          = (wr && ofs == GPIO_STAT_OFS) ? wd : '0;
   assign o_pready     = (state == APB_READY);

   always_comb begin
      rdata = '0;
      if (addr_ok)
         rdata = (ofs == GPIO_DATA_OFS) ? APB_DATA_WIDTH'(deb)     :
                 (ofs == GPIO_RAW_OFS)  ? APB_DATA_WIDTH'(raw)     :
                 (ofs == GPIO_RISE_OFS) ? APB_DATA_WIDTH'(rise_en) :
                 (ofs == GPIO_FALL_OFS) ? APB_DATA_WIDTH'(fall_en) :
                 (ofs == GPIO_STAT_OFS) ? APB_DATA_WIDTH'(status)  :
                                          APB_DATA_WIDTH'(mask);
   end

   always_comb begin
      state_nx = APB_IDLE;
      if (access) state_nx = APB_READY;
   end

   always_ff @(posedge pclk or negedge pnreset)
      if (!pnreset) state <= APB_IDLE;
      else          state <= state_nx;

   always_ff @(posedge pclk or negedge pnreset)
      if (!pnreset) begin
         o_prdata  <= '0;
         o_pslverr <= 1'b0;
         o_irq     <= 1'b0;
         rise_en   <= '0;
         fall_en   <= '0;
         status    <= '0;
         mask      <= '0;
      end else begin
         o_pslverr <= access & ~addr_ok;
         if (access && !i_pwrite) o_prdata <= rdata;
         if (wr && ofs == GPIO_RISE_OFS) rise_en <= wd;
         if (wr && ofs == GPIO_FALL_OFS) fall_en <= wd;
         if (wr && ofs == GPIO_MASK_OFS) mask    <= wd;
         // a new edge on the same cycle as its W1C clear keeps the bit set
         status <= (status & ~clr) | set;
         o_irq  <= |(status & mask);
      end
endmodule

// File: tb/tb_apb_switch_gpio.sv
// tb_apb_switch_gpio: directed self-checking bench for apb_switch_gpio (D=4, 8 channels)
module tb_apb_switch_gpio;
   logic        clk = 1'b0;
   logic        pnreset;
   logic        psel, penable, pwrite;
   logic [15:0] paddr, pwdata;
   logic [7:0]  sw;
   logic        pready, pslverr, irq;
   logic [15:0] prdata;
   int          n_cmp = 0;
   int          n_bad = 0;

   apb_switch_gpio dut (
      .pclk      (clk),
      .pnreset   (pnreset),
      .i_psel    (psel),
      .i_penable (penable),
      .i_pwrite  (pwrite),
      .i_paddr   (paddr),
      .i_pwdata  (pwdata),
      .i_switch  (sw),
      .o_pready  (pready),
      .o_prdata  (prdata),
      .o_pslverr (pslverr),
      .o_irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // entered and left at posedge+1; rdy0 after the access-phase edge, rdy1 after the next
   task automatic apb(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic err, output logic rdy0, output logic rdy1);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      rdy0 = pready;
      @(posedge clk); #1;
      rd = prdata; err = pslverr; rdy1 = pready;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [15:0] rd;
      logic        err, r0, r1;
      pnreset = 1'b0; sw = 8'hA5;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({pready, pslverr, irq, prdata} !== 19'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {pready, pslverr, irq, prdata});
      end
      @(negedge clk) pnreset = 1'b1;
      idle(10);
      apb(1'b0, 16'h0000, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({r0, r1} !== 2'b01) begin
         n_bad++; $display("FAIL reset_ready_timing: got %b want 01", {r0, r1});
      end
      n_cmp++;
      if (rd !== 16'h00A5 || err !== 1'b0) begin
         n_bad++; $display("FAIL reset_data_read: got %h/%b want 00a5/0", rd, err);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++; $display("FAIL reset_irq: got %b want 0", irq);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (pready !== 1'b0) begin
         n_bad++; $display("FAIL ready_one_cycle: got %b want 0", pready);
      end
      apb(1'b0, 16'h0004, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h00A5 || err !== 1'b0) begin
         n_bad++; $display("FAIL raw_read: got %h/%b want 00a5/0", rd, err);
      end
      sw = 8'h00;
      idle(10);
   endtask

   task automatic test_debounce;
      logic [15:0] rd;
      logic        err, r0, r1;
      logic        early;
      sw[0] = 1'b1;
      idle(3);
      sw[0] = 1'b0;
      idle(10);
      apb(1'b0, 16'h0000, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0000) begin
         n_bad++; $display("FAIL glitch_data: got %h want 0000", rd);
      end
      apb(1'b0, 16'h0010, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0000) begin
         n_bad++; $display("FAIL glitch_status: got %h want 0000", rd);
      end
      sw[0] = 1'b1;
      early = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         early = early | dut.deb[0];
      end
      n_cmp++;
      if (early !== 1'b0) begin
         n_bad++; $display("FAIL debounce_too_early: got %b want 0", early);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dut.deb[0] !== 1'b1) begin
         n_bad++; $display("FAIL debounce_edge6: got %b want 1", dut.deb[0]);
      end
      idle(2);
      apb(1'b0, 16'h0000, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0001) begin
         n_bad++; $display("FAIL held_data: got %h want 0001", rd);
      end
   endtask

   task automatic test_rise_irq;
      logic [15:0] rd;
      logic        err, r0, r1;
      sw[0] = 1'b0;
      idle(10);
      apb(1'b1, 16'h0008, 16'h0001, rd, err, r0, r1);
      apb(1'b1, 16'h0014, 16'h0001, rd, err, r0, r1);
      apb(1'b0, 16'h0010, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0000) begin
         n_bad++; $display("FAIL no_status_on_fall: got %h want 0000", rd);
      end
      sw[0] = 1'b1;
      idle(5);
      n_cmp++;
      if ({dut.status[0], irq} !== 2'b00) begin
         n_bad++; $display("FAIL rise_before: got %b want 00", {dut.status[0], irq});
      end
      idle(1);
      n_cmp++;
      if ({dut.status[0], irq} !== 2'b10) begin
         n_bad++; $display("FAIL rise_status_edge: got %b want 10", {dut.status[0], irq});
      end
      idle(1);
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++; $display("FAIL irq_latency: got %b want 1", irq);
      end
      apb(1'b0, 16'h0010, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0001) begin
         n_bad++; $display("FAIL status_read: got %h want 0001", rd);
      end
      apb(1'b1, 16'h0010, 16'h0001, rd, err, r0, r1);
      n_cmp++;
      if ({dut.status[0], irq} !== 2'b01) begin
         n_bad++; $display("FAIL w1c_edge: got %b want 01", {dut.status[0], irq});
      end
      idle(1);
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++; $display("FAIL irq_fall: got %b want 0", irq);
      end
   endtask

   task automatic test_set_wins;
      logic [15:0] rd;
      logic        err, r0, r1;
      apb(1'b1, 16'h000C, 16'h0002, rd, err, r0, r1);
      sw[1] = 1'b1;
      idle(10);
      sw[1] = 1'b0;
      idle(4);
      apb(1'b1, 16'h0010, 16'h0002, rd, err, r0, r1);
      n_cmp++;
      if (dut.deb[1] !== 1'b0 || dut.status !== 8'h02) begin
         n_bad++; $display("FAIL set_wins_edge: got deb %b status %h want 0/02", dut.deb[1], dut.status);
      end
      apb(1'b0, 16'h0010, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0002 || irq !== 1'b0) begin
         n_bad++; $display("FAIL set_wins_read: got %h/%b want 0002/0", rd, irq);
      end
   endtask

   task automatic test_bad_addr;
      logic [15:0] rd;
      logic        err, r0, r1;
      apb(1'b0, 16'h0018, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({r1, err, rd} !== {2'b11, 16'h0000}) begin
         n_bad++; $display("FAIL bad_read_18: got %b%b/%h want 11/0000", r1, err, rd);
      end
      apb(1'b0, 16'h0002, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({r1, err, rd} !== {2'b11, 16'h0000}) begin
         n_bad++; $display("FAIL bad_read_02: got %b%b/%h want 11/0000", r1, err, rd);
      end
      apb(1'b0, 16'h0108, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({err, rd} !== {1'b1, 16'h0000}) begin
         n_bad++; $display("FAIL bad_read_upper: got %b/%h want 1/0000", err, rd);
      end
      apb(1'b1, 16'h0018, 16'hFFFF, rd, err, r0, r1);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++; $display("FAIL bad_write_18: got %b want 1", err);
      end
      apb(1'b1, 16'h0114, 16'hFFFF, rd, err, r0, r1);
      apb(1'b1, 16'h0016, 16'hFFFF, rd, err, r0, r1);
      apb(1'b1, 16'h0109, 16'hFFFF, rd, err, r0, r1);
      apb(1'b0, 16'h0008, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({err, rd} !== {1'b0, 16'h0001}) begin
         n_bad++; $display("FAIL rise_en_kept: got %b/%h want 0/0001", err, rd);
      end
      apb(1'b0, 16'h000C, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0002) begin
         n_bad++; $display("FAIL fall_en_kept: got %h want 0002", rd);
      end
      apb(1'b0, 16'h0010, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0002) begin
         n_bad++; $display("FAIL status_kept: got %h want 0002", rd);
      end
      apb(1'b0, 16'h0014, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if (rd !== 16'h0001) begin
         n_bad++; $display("FAIL mask_kept: got %h want 0001", rd);
      end
      apb(1'b1, 16'h0014, 16'h0003, rd, err, r0, r1);
      n_cmp++;
      if ({r1, err, rd} !== {2'b10, 16'h0001}) begin
         n_bad++; $display("FAIL prdata_hold_on_write: got %b%b/%h want 10/0001", r1, err, rd);
      end
   endtask

   task automatic test_reset_mid_transfer;
      logic [15:0] rd;
      logic        err, r0, r1;
      idle(2);
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++; $display("FAIL irq_before_reset: got %b want 1", irq);
      end
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0008;
      @(posedge clk); #1;
      penable = 1'b1;
      #2 pnreset = 1'b0;
      #1;
      n_cmp++;
      if ({pready, irq, dut.status, prdata} !== 26'd0) begin
         n_bad++; $display("FAIL async_reset: got rdy %b irq %b status %h prdata %h want all 0",
                           pready, irq, dut.status, prdata);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (pready !== 1'b0) begin
         n_bad++; $display("FAIL dropped_transfer: got %b want 0", pready);
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk) pnreset = 1'b1;
      idle(10);
      apb(1'b0, 16'h0008, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({r0, r1, err, rd} !== {3'b010, 16'h0000}) begin
         n_bad++; $display("FAIL post_reset_rise_en: got %b%b%b/%h want 010/0000", r0, r1, err, rd);
      end
      apb(1'b0, 16'h0000, 16'h0, rd, err, r0, r1);
      n_cmp++;
      if ({err, rd} !== {1'b0, 16'h0001}) begin
         n_bad++; $display("FAIL post_reset_data: got %b/%h want 0/0001", err, rd);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_rise_irq();
      test_set_wins();
      test_bad_addr();
      test_reset_mid_transfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
